// File: rtl/serail_uart_pkg.sv
// rtl/serail_uart_pkg.sv - shared register map, status bit indices and FSM encodings
package serail_uart_pkg;

  typedef logic [0:0]  serail_addr_bus_t;
  typedef logic [31:0] ram_bus_t;

  localparam serail_addr_bus_t SERAIL_ADDR_DATA   = 1'b0;
  localparam serail_addr_bus_t SERAIL_ADDR_STATUS = 1'b1;

  localparam int SERAIL_ST_TXIDLE   = 0;
  localparam int SERAIL_ST_RXVALID  = 1;
  localparam int SERAIL_ST_OVERRUN  = 2;
  localparam int SERAIL_ST_FRAMEERR = 3;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/serail_uart_fifo.sv
// rtl/serail_uart_fifo.sv - show-ahead synchronous FIFO; a pop frees a slot for a same-cycle push
module serail_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/serail_uart.sv
// rtl/serail_uart.sv - 8N1 UART on the CPU serail bus with RX FIFO and level interrupt
// SERAIL_LOOPBACK_EN feeds the internal TX line into RX and parks uart_tx_o high.
module serail_uart
  import serail_uart_pkg::*;
#(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serail_ce_i,
  input  logic             serail_we_i,
  input  serail_addr_bus_t serail_addr_i,
  input  logic [31:0]      serail_data_i,
  output logic [31:0]      serail_data_o,
  output logic             serail_ready_o,
  input  logic             uart_rx_i,
  output logic             uart_tx_o,
  output logic             rx_int_o
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_END  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);

  logic          acc_q, acc_d, ready_q, ready_d;
  logic [31:0]   rdata_q, rdata_d, status;
  logic          tx_go_q, tx_go_d, tx_go_set, tx_free;
  logic [7:0]    tx_byte_q, tx_byte_d, tx_shift_q, tx_shift_d;
  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_idx_q, tx_idx_d;
  logic          tx_line_q, tx_line_d;
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_idx_q, rx_idx_d, rx_sync_q, rx_sync_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic          rx_src, rx_bit, rx_push, frame_set, st_clear;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic          unused_data;

  assign unused_data = ^serail_data_i[31:8];

`ifdef SERAIL_LOOPBACK_EN
  logic unused_rx_pin;
  assign unused_rx_pin = uart_rx_i;
  assign rx_src        = tx_line_q;
  assign uart_tx_o     = 1'b1;
`else
  assign rx_src    = uart_rx_i;
  assign uart_tx_o = tx_line_q;
`endif

  assign serail_ready_o = ready_q;
  assign serail_data_o  = rdata_q;
  assign rx_int_o       = !fifo_empty;
  assign tx_free        = (tx_state_q == TX_IDLE) && !tx_go_q;

  always_comb begin
    status = '0;
    status[SERAIL_ST_TXIDLE]   = (tx_state_q == TX_IDLE);
    status[SERAIL_ST_RXVALID]  = !fifo_empty;
    status[SERAIL_ST_OVERRUN]  = overrun_q;
    status[SERAIL_ST_FRAMEERR] = frame_err_q;
  end

  // Bus handshake: accept, then complete (or stall a DATA write while TX is busy).
  always_comb begin
    acc_d     = acc_q;
    ready_d   = 1'b0;
    rdata_d   = '0;
    fifo_pop  = 1'b0;
    st_clear  = 1'b0;
    tx_go_set = 1'b0;
    tx_byte_d = tx_byte_q;
    if (!acc_q) begin
      acc_d = serail_ce_i && !ready_q;
    end else if (!serail_ce_i) begin
      acc_d = 1'b0;
    end else if (serail_we_i) begin
      if (serail_addr_i == SERAIL_ADDR_STATUS || tx_free) begin
        acc_d   = 1'b0;
        ready_d = 1'b1;
        if (serail_addr_i == SERAIL_ADDR_DATA) begin
          tx_go_set = 1'b1;
          tx_byte_d = serail_data_i[7:0];
        end
      end
    end else begin
      acc_d   = 1'b0;
      ready_d = 1'b1;
      if (serail_addr_i == SERAIL_ADDR_STATUS) begin
        rdata_d  = status;
        st_clear = 1'b1;
      end else if (!fifo_empty) begin
        fifo_pop = 1'b1;
        rdata_d  = {24'b0, fifo_dout};
      end
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = (tx_cnt_q == BIT_END) ? '0 : tx_cnt_q + 1'b1;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_go_d    = tx_go_q | tx_go_set;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (tx_go_q) begin
          tx_state_d = TX_START;
          tx_go_d    = 1'b0;
          tx_shift_d = tx_byte_q;
        end
      end
      TX_START: if (tx_cnt_q == BIT_END) begin
        tx_state_d = TX_DATA;
        tx_idx_d   = '0;
      end
      TX_DATA: if (tx_cnt_q == BIT_END) begin
        tx_shift_d = {1'b0, tx_shift_q[7:1]};
        tx_idx_d   = tx_idx_q + 1'b1;
        if (tx_idx_q == 3'd7) tx_state_d = TX_STOP;
      end
      TX_STOP: if (tx_cnt_q == BIT_END) tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
    unique case (tx_state_d)
      TX_START: tx_line_d = 1'b0;
      TX_DATA:  tx_line_d = tx_shift_d[0];
      default:  tx_line_d = 1'b1;
    endcase
  end

  // rx_sync_q[1] is the synchronised line, rx_sync_q[2] its previous value.
  always_comb begin
    rx_sync_d  = {rx_sync_q[1:0], rx_src};
    rx_bit     = rx_sync_q[1];
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    frame_set  = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_sync_q[2] && !rx_bit) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == HALF_END) begin
        rx_cnt_d   = '0;
        rx_idx_d   = '0;
        rx_state_d = rx_bit ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == BIT_END) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_bit, rx_shift_q[7:1]};
        rx_idx_d   = rx_idx_q + 1'b1;
        if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt_q == BIT_END) begin
        rx_state_d = RX_IDLE;
        rx_push    = rx_bit;
        frame_set  = !rx_bit;
      end
      default: rx_state_d = RX_IDLE;
    endcase
    overrun_d   = (rx_push && fifo_full && !fifo_pop) | (overrun_q & ~st_clear);
    frame_err_d = frame_set | (frame_err_q & ~st_clear);
  end

  serail_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (fifo_pop),
    .din   (rx_shift_q),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= 1'b0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      tx_go_q     <= 1'b0;
      tx_byte_q   <= '0;
      tx_shift_q  <= '0;
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_idx_q    <= '0;
      tx_line_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_idx_q    <= '0;
      rx_shift_q  <= '0;
      rx_sync_q   <= 3'b111;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      tx_go_q     <= tx_go_d;
      tx_byte_q   <= tx_byte_d;
      tx_shift_q  <= tx_shift_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_idx_q    <= tx_idx_d;
      tx_line_q   <= tx_line_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_idx_q    <= rx_idx_d;
      rx_shift_q  <= rx_shift_d;
      rx_sync_q   <= rx_sync_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_serail_uart.sv
// tb/tb_serail_uart.sv - directed bench for serail_uart with BAUD_DIV=4, FIFO_DEPTH=16
module tb_serail_uart;
  logic        clk = 1'b0;
  logic        rst, ce, we, rx;
  logic [0:0]  addr;
  logic [31:0] wdata, rdata_o;
  logic        ready, tx, irq;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  serail_uart #(.BAUD_DIV(4), .FIFO_DEPTH(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .serail_ce_i    (ce),
    .serail_we_i    (we),
    .serail_addr_i  (addr),
    .serail_data_i  (wdata),
    .serail_data_o  (rdata_o),
    .serail_ready_o (ready),
    .uart_rx_i      (rx),
    .uart_tx_o      (tx),
    .rx_int_o       (irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_xfer(input logic w, input logic a, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
    lat = 0;
    @(negedge clk);
    ce = 1'b1; we = w; addr[0] = a; wdata = wd;
    do begin
      @(negedge clk);
      lat++;
    end while (!ready && lat < 200);
    rd = rdata_o;
    ce = 1'b0; we = 1'b0; wdata = '0;
  endtask

  task automatic bus_rd(input string tag, input logic a, input logic [31:0] exp, input int exp_lat);
    logic [31:0] d;
    int          lat;
    bus_xfer(1'b0, a, 32'h0, d, lat);
    chk({tag, "_data"}, d, exp);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic bus_wr(input string tag, input logic [7:0] b, input int exp_lat);
    logic [31:0] d;
    int          lat;
    bus_xfer(1'b1, 1'b0, {24'h0, b}, d, lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic tx_frame_check(input string tag, input logic [7:0] b);
    logic [9:0] fr;
    logic [3:0] obs;
    fr = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        obs[c] = tx;
      end
      chk($sformatf("%s_bit%0d", tag, k), 32'(obs), 32'({4{fr[k]}}));
    end
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk) rx = fr[k];
      repeat (3) @(negedge clk);
    end
    @(negedge clk) rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; we = 1'b0; addr = '0; wdata = '0; rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_data", rdata_o, 32'h0);
    chk("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;

    bus_rd("st_reset", 1'b1, 32'h1, 2);
    @(negedge clk);
    chk("data_back_to_zero", rdata_o, 32'h0);
    chk("ready_one_pulse", 32'(ready), 32'd0);

    bus_wr("wr_a5", 8'hA5, 2);
    tx_frame_check("tx_a5", 8'hA5);
    bus_rd("st_after_a5", 1'b1, 32'h1, 2);

    bus_wr("wr_5a", 8'h5A, 2);
    bus_wr("wr_c3_stall", 8'hC3, 41);
    tx_frame_check("tx_c3", 8'hC3);
    repeat (5) @(negedge clk);

    rx_send(8'h3C, 1'b1);
    chk("irq_rise", 32'(irq), 32'd1);
    bus_rd("rx_3c", 1'b0, 32'h3C, 2);
    chk("irq_fall", 32'(irq), 32'd0);
    bus_rd("rx_empty", 1'b0, 32'h0, 2);

    for (int i = 0; i < 17; i++) rx_send(8'(16 + i), 1'b1);
    bus_wr("wr_busy", 8'h00, 2);
    bus_rd("st_overrun", 1'b1, 32'h6, 2);
    bus_rd("st_cleared", 1'b1, 32'h2, 2);
    for (int i = 0; i < 16; i++) bus_rd($sformatf("drain%0d", i), 1'b0, 32'(16 + i), 2);
    bus_rd("drain_empty", 1'b0, 32'h0, 2);
    chk("irq_drained", 32'(irq), 32'd0);

    repeat (50) @(negedge clk);
    rx_send(8'h55, 1'b0);
    chk("frame_err_irq", 32'(irq), 32'd0);
    bus_rd("st_frame_err", 1'b1, 32'h9, 2);
    bus_rd("st_frame_clr", 1'b1, 32'h1, 2);

    @(negedge clk) rx = 1'b0;
    @(negedge clk) rx = 1'b1;
    repeat (10) @(negedge clk);
    chk("glitch_irq", 32'(irq), 32'd0);
    bus_rd("st_glitch", 1'b1, 32'h1, 2);

    bus_wr("wr_00", 8'h00, 2);
    repeat (10) @(negedge clk);
    chk("mid_frame_low", 32'(tx), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx", 32'(tx), 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_tx", 32'(tx), 32'd1);
    bus_rd("st_post_rst", 1'b1, 32'h1, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serail_uart.md
# serail_uart

Synthesizable 8N1 UART that replaces the simulation serial model on the CPU's serial bus. It converts CPU bus reads and writes into bytes on the serial TX line and collects bytes from the RX line into a receive FIFO. It also raises a level interrupt for the COM1 slot of the CPU's external interrupt vector. The block sits between the CPU's `serail_*` bus port and the board's serial pins.

## Interface
Parameters:
- `BAUD_DIV`, default 434: clk cycles per bit (50 MHz / 115200).
- `FIFO_DEPTH`, default 16: RX FIFO entries; must be a power of two, at least 2.

Ports:
- `clk`  in  1: bus clock; single clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `serail_ce_i`  in  1: bus access strobe, held until `serail_ready_o`.
- `serail_we_i`  in  1: 1 = write, 0 = read.
- `serail_addr_i`  in  1 (`SerailAddrBus`): 0 = DATA, 1 = STATUS.
- `serail_data_i`  in  32 (`RAMBus`): write data; bits [7:0] used.
- `serail_data_o`  out  32 (`RAMBus`): read data, zero-extended.
- `serail_ready_o`  out  1: one-cycle access-complete pulse.
- `uart_rx_i`  in  1: asynchronous serial input; idle high.
- `uart_tx_o`  out  1: serial output; idle high.
- `rx_int_o`  out  1: high while the RX FIFO is non-empty; drives `int_i[4]`.

## Operation
- **Register map**
  - DATA read pops the FIFO head; it returns 0 if the FIFO is empty, with no pop.
  - DATA write queues [7:0] for transmission.
  - STATUS read returns: bit0 `tx_idle`, bit1 `rx_valid`, bit2 `rx_overrun`, bit3 `rx_frame_err`; bits [31:4] = 0.
  - Bits 2 and 3 are sticky and clear on the cycle a STATUS read completes.
  - STATUS write is accepted and ignored.
- **Bus handshake**
  - An access starts on the first cycle with `serail_ce_i` high while no ready pulse is in flight.
  - Reads always complete.
  - A DATA write completes only when the TX FSM is IDLE. Otherwise `serail_ready_o` stays low, stalling the CPU, until TX returns to IDLE.
  - `ce` dropping before ready abandons the access with no side effects.
- **TX FSM**
  - States IDLE → START → DATA(8 bits, LSB first) → STOP → IDLE.
  - Each state lasts `BAUD_DIV` cycles, counted by a bit counter.
  - `tx_idle` = state is IDLE.
- **RX path**
  - `uart_rx_i` passes through a 2-flop synchronizer.
  - RX FSM states: IDLE → START → DATA → STOP.
  - A falling edge in IDLE enters START. The line is resampled after `BAUD_DIV/2` cycles; if high, the FSM returns to IDLE (glitch).
  - Data bits are sampled every `BAUD_DIV` cycles at bit centre.
  - In STOP, a low sample sets `rx_frame_err` and drops the byte. A high sample pushes the byte.
  - Push into a full FIFO drops the byte and sets `rx_overrun`.
- **Simultaneous events**
  - A push and a pop in the same cycle both take effect; count is unchanged.
  - A push into a full FIFO in the same cycle as a pop succeeds.
  - A sticky-bit set and a STATUS-read clear in the same cycle: the set wins.

## Timing
- Reset values:
  - `uart_tx_o` = 1.
  - `serail_ready_o` = 0.
  - `serail_data_o` = 0.
  - `rx_int_o` = 0.
  - FIFO empty, both FSMs IDLE, sticky bits 0.
- Read latency: `ce` sampled at edge N; `serail_ready_o` and `serail_data_o` are valid for one cycle after edge N+1. `serail_data_o` returns to 0 afterwards.
- Idle write latency: same as read latency. `uart_tx_o` falls (start bit) at the edge after ready.
- Frame length: 10×`BAUD_DIV` cycles. The byte is visible (`rx_int_o` high) one cycle after the stop-bit centre sample.
- Reset mid-frame abandons both FSMs immediately and forces `uart_tx_o` high.
- FIFO pointers are log2(`FIFO_DEPTH`) bits and wrap modulo depth. The occupancy counter is one bit wider.

## Configuration
- `SERAIL_LOOPBACK_EN`
  - Defined: the RX synchronizer input is taken from the internal TX line instead of `uart_rx_i`, and `uart_tx_o` is held at 1. Used for board self-test.
  - Undefined: normal pin operation, and `uart_rx_i` feeds RX.

## Structure
- `defines.v` holds:
  - `SERAIL_ADDR_DATA`/`SERAIL_ADDR_STATUS`.
  - Status bit indices `SERAIL_ST_TXIDLE`, `_RXVALID`, `_OVERRUN`, `_FRAMEERR`.
  - TX/RX state encodings.
  - `SerailAddrBus` ([0:0]).
- Sub-module `serail_fifo`: synchronous FIFO with parameters width and depth. Ports: push, pop, din, dout (show-ahead), full, empty.

## Test plan
- Reset, then STATUS read → `serail_data_o`=0x00000001, `uart_tx_o`=1, `rx_int_o`=0.
- DATA write 0x000000A5 (`BAUD_DIV`=4) → ready after 1 cycle. Line shows 0, then 1,0,1,0,0,1,0,1, then 1, each bit 4 cycles. `tx_idle` is 0 for 40 cycles.
- Second DATA write issued during a frame → `serail_ready_o` held low until TX returns to IDLE, then one pulse; the next frame follows immediately.
- Drive RX frame 0x3C → `rx_int_o` rises. DATA read returns 0x0000003C and `rx_int_o` falls. A second DATA read returns 0.
- Send 17 frames with `FIFO_DEPTH`=16 → 16 bytes buffered. STATUS reads 0x6, then 0x2 on the next read.
- RX frame with stop bit low → byte dropped and STATUS bit3 set. A 1-cycle low glitch on idle RX → no byte and no flags.
